// File: rtl/dm_access.sv
// Data-memory access unit: runs byte/half/word loads and stores against an internal word RAM with LAT-cycle latency.
// Optional alignment checking with an Exc output is enabled by defining DM_ALIGN_CHK_EN.
module dm_access #(
    parameter int AW  = 10,
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        We,
    input  logic [3:0]  BE,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [2:0]  LdSel,
    output logic [31:0] RD,
    output logic        Busy,
`ifdef DM_ALIGN_CHK_EN
    output logic        Exc,
`endif
    output logic        Done
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wd_q, wd_d;
    logic [2:0]      ldsel_q, ldsel_d;
    logic [31:0]     rd_q, rd_d;
    logic            done_q, done_d;
`ifdef DM_ALIGN_CHK_EN
    logic            exc_q, exc_d;
`endif

    logic [31:0]     mem [0:(2**AW)-1];
    logic [31:0]     mem_rd_q;
    logic [AW-1:0]   rd_word;
    logic            commit;
    logic            misalign;
    logic [31:0]     wa;
    logic [3:0]      lane_we;
    logic [31:0]     f_word;
    logic [15:0]     h_word;
    logic [31:0]     load_val;
    logic            unused_addr;

    assign unused_addr = ^Addr[31:AW+2];

    assign commit = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        misalign = 1'b0;
`ifdef DM_ALIGN_CHK_EN
        if (we_q) begin
            if (be_q == 4'b1111) begin
                misalign = (addr_q[1:0] != 2'b00);
            end else if (be_q == 4'b1100 || be_q == 4'b0011) begin
                misalign = addr_q[0];
            end
        end else begin
            case (ldsel_q)
                LD_LH, LD_LHU: misalign = addr_q[0];
                LD_LB, LD_LBU: misalign = 1'b0;
                default:       misalign = (addr_q[1:0] != 2'b00);
            endcase
        end
`endif
    end

    // Store data is right-justified; move it onto the lanes the mask selects.
    always_comb begin
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wa = wd_q << {addr_q[1:0], 3'b000};
            4'b0011, 4'b1100:                   wa = wd_q << {addr_q[1], 4'b0000};
            default:                            wa = wd_q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = commit && we_q && be_q[gi] && !misalign;
        end
    endgenerate

    // While idle the RAM is read at the incoming address so LAT=1 still sees a registered word at commit.
    assign rd_word = (state_q == IDLE) ? Addr[AW+1:2] : addr_q[AW+1:2];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                mem[addr_q[AW+1:2]][8*k +: 8] <= wa[8*k +: 8];
            end
        end
        mem_rd_q <= mem[rd_word];
    end

    always_comb begin
        f_word = mem_rd_q >> {addr_q[1:0], 3'b000};
        h_word = addr_q[1] ? mem_rd_q[31:16] : mem_rd_q[15:0];
        case (ldsel_q)
            LD_LH:   load_val = {{16{h_word[15]}}, h_word};
            LD_LHU:  load_val = {16'h0000, h_word};
            LD_LB:   load_val = {{24{f_word[7]}}, f_word[7:0]};
            LD_LBU:  load_val = {24'h000000, f_word[7:0]};
            default: load_val = f_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        ldsel_d = ldsel_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
`ifdef DM_ALIGN_CHK_EN
        exc_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LAT - 1);
                    we_d    = We;
                    be_d    = BE;
                    addr_d  = Addr[AW+1:0];
                    wd_d    = WD;
                    ldsel_d = LdSel;
                end
            end
            default: begin
                if (commit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!we_q && !misalign) begin
                        rd_d = load_val;
                    end
`ifdef DM_ALIGN_CHK_EN
                    exc_d = misalign;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wd_q    <= 32'h0;
            ldsel_q <= 3'b000;
            rd_q    <= 32'h0;
            done_q  <= 1'b0;
`ifdef DM_ALIGN_CHK_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            ldsel_q <= ldsel_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
`ifdef DM_ALIGN_CHK_EN
            exc_q   <= exc_d;
`endif
        end
    end

    assign RD   = rd_q;
    assign Busy = (state_q == ACCESS);
    assign Done = done_q;
`ifdef DM_ALIGN_CHK_EN
    assign Exc  = exc_q;
`endif

endmodule
